// File: rtl/pu_msp430_wakeup_ctrl.sv
// Multi-channel synchronous wakeup controller: per-channel synchronizer, glitch filter,
// edge qualification, enable mask and sticky pending flags with W1C and ack clearing.
module pu_msp430_wakeup_ctrl #(
    parameter  int WKUP_NR     = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int FILT_CYCLES = 4,
    localparam int ID_W        = (WKUP_NR > 1) ? $clog2(WKUP_NR) : 1
) (
    input  logic                   mclk,
    input  logic                   reset_n,
    input  logic [WKUP_NR-1:0]     wkup_in,
    input  logic [WKUP_NR-1:0]     wkup_en,
    input  logic [2*WKUP_NR-1:0]   wkup_edge_sel,
    input  logic [WKUP_NR-1:0]     wkup_clear,
    input  logic                   wkup_ack,
    output logic [WKUP_NR-1:0]     wkup_pend,
    output logic                   wkup_out,
    output logic [ID_W-1:0]        wkup_id
);

    localparam int CNT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [WKUP_NR-1:0][SYNC_STAGES-1:0] sync_q;
    logic [WKUP_NR-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WKUP_NR-1:0]                  flt_q, flt_d;
    logic [WKUP_NR-1:0]                  pend_q, pend_d;
    logic [WKUP_NR-1:0]                  sync_out;
    logic [ID_W-1:0]                     id_d;

    always_comb begin
        for (int i = 0; i < WKUP_NR; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Filter counts consecutive mismatches; the flip edge doubles as the event edge.
    always_comb begin
        logic flip;
        logic qual;
        logic ack_hit;
        cnt_d  = cnt_q;
        flt_d  = flt_q;
        pend_d = pend_q;
        for (int i = 0; i < WKUP_NR; i++) begin
            flip    = 1'b0;
            if (sync_out[i] == flt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i] = '0;
                flt_d[i] = sync_out[i];
                flip     = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            qual    = flip & ((~flt_q[i] & wkup_edge_sel[2*i]) |
                              ( flt_q[i] & wkup_edge_sel[2*i+1]));
            ack_hit = wkup_ack & wkup_out & (wkup_id == ID_W'(i));
            if (qual & wkup_en[i]) begin
                pend_d[i] = 1'b1;
            end else if (wkup_clear[i] | ack_hit) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        id_d = '0;
        for (int i = WKUP_NR - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                id_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            flt_q  <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < WKUP_NR; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], wkup_in[i]};
            end
            cnt_q  <= cnt_d;
            flt_q  <= flt_d;
            pend_q <= pend_d;
        end
    end

    assign wkup_pend = pend_q;
    assign wkup_out  = |pend_q;
    assign wkup_id   = id_d;

endmodule

// File: tb/tb_pu_msp430_wakeup_ctrl.sv
// Self-checking bench for pu_msp430_wakeup_ctrl: directed scenarios plus random traffic
// compared every cycle against a sliding-window behavioural model.
module tb_pu_msp430_wakeup_ctrl;

    localparam int NR    = 4;
    localparam int S     = 2;
    localparam int F     = 3;
    localparam int DEPTH = S + F - 1;
    localparam int IDW   = 2;

    logic              mclk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     wkup_in, wkup_en, wkup_clear;
    logic [2*NR-1:0]   wkup_edge_sel;
    logic              wkup_ack;
    logic [NR-1:0]     wkup_pend;
    logic              wkup_out;
    logic [IDW-1:0]    wkup_id;

    int checks   = 0;
    int failures = 0;

    pu_msp430_wakeup_ctrl #(
        .WKUP_NR     (NR),
        .SYNC_STAGES (S),
        .FILT_CYCLES (F)
    ) dut (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .wkup_in       (wkup_in),
        .wkup_en       (wkup_en),
        .wkup_edge_sel (wkup_edge_sel),
        .wkup_clear    (wkup_clear),
        .wkup_ack      (wkup_ack),
        .wkup_pend     (wkup_pend),
        .wkup_out      (wkup_out),
        .wkup_id       (wkup_id)
    );

    always #5 mclk = ~mclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] inV, input logic [NR-1:0] enV,
                                 input logic [2*NR-1:0] selV, input logic [NR-1:0] clrV,
                                 input logic ackV);
        wkup_in       = inV;
        wkup_en       = enV;
        wkup_edge_sel = selV;
        wkup_clear    = clrV;
        wkup_ack      = ackV;
    endtask

    function automatic int lowestOf(input logic [NR-1:0] p);
        int r = 0;
        for (int i = NR - 1; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    // Reference model: history of sampled inputs; flt flips when the last F synchronized samples all differ from it.
    bit            hist [NR][DEPTH];
    bit            mFlt [NR];
    logic [NR-1:0] mPend = '0;

    initial begin
        forever begin
            @(posedge mclk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < NR; i++) begin
                    mFlt[i] = 1'b0;
                    for (int k = 0; k < DEPTH; k++) hist[i][k] = 1'b0;
                end
                mPend = '0;
            end else begin
                logic [NR-1:0] nextPend;
                bit anyP, allDiff, wasLow, ev;
                int lowId;
                anyP  = |mPend;
                lowId = lowestOf(mPend);
                for (int i = 0; i < NR; i++) begin
                    allDiff = 1'b1;
                    for (int k = 0; k < F; k++) if (hist[i][S-1+k] == mFlt[i]) allDiff = 1'b0;
                    ev = 1'b0;
                    if (allDiff) begin
                        wasLow  = !mFlt[i];
                        mFlt[i] = !mFlt[i];
                        ev = wasLow ? wkup_edge_sel[2*i] : wkup_edge_sel[2*i+1];
                    end
                    if (ev && wkup_en[i]) nextPend[i] = 1'b1;
                    else if (wkup_clear[i] || (wkup_ack && anyP && lowId == i)) nextPend[i] = 1'b0;
                    else nextPend[i] = mPend[i];
                    for (int k = DEPTH - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = wkup_in[i];
                end
                mPend = nextPend;
            end
        end
    end

    initial begin
        forever begin
            @(negedge mclk);
            if (reset_n === 1'b1) begin
                checkOutput("model_pend", wkup_pend, mPend);
                checkOutput("model_out", wkup_out, |mPend);
                checkOutput("model_id", wkup_id, lowestOf(mPend));
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    initial begin
        applyStimulus('0, '0, '0, '0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset_pend", wkup_pend, 0);
        checkOutput("reset_out", wkup_out, 0);
        checkOutput("reset_id", wkup_id, 0);

        // Scenario 1: latency of five edges
        @(negedge mclk);
        wkup_edge_sel[1:0] = 2'b01; wkup_en[0] = 1'b1; wkup_in[0] = 1'b1;
        waitEdges(4);
        checkOutput("t1_pend_edge4", wkup_pend[0], 0);
        checkOutput("t1_out_edge4", wkup_out, 0);
        waitEdges(1);
        checkOutput("t1_pend_edge5", wkup_pend[0], 1);
        checkOutput("t1_out_edge5", wkup_out, 1);

        // Scenario 2: glitch rejection
        @(negedge mclk);
        wkup_edge_sel[3:2] = 2'b01; wkup_en[1] = 1'b1; wkup_in[1] = 1'b1;
        repeat (2) @(posedge mclk);
        @(negedge mclk); wkup_in[1] = 1'b0;
        waitEdges(8);
        checkOutput("t2_short_pulse", wkup_pend[1], 0);
        @(negedge mclk); wkup_in[1] = 1'b1;
        repeat (3) @(posedge mclk);
        @(negedge mclk); wkup_in[1] = 1'b0;
        waitEdges(8);
        checkOutput("t2_long_pulse", wkup_pend[1], 1);

        // Scenario 3: edge modes on channel 2
        @(negedge mclk);
        wkup_edge_sel[5:4] = 2'b10; wkup_en[2] = 1'b1; wkup_in[2] = 1'b1;
        waitEdges(10);
        checkOutput("t3_fall_on_rise", wkup_pend[2], 0);
        @(negedge mclk); wkup_in[2] = 1'b0;
        waitEdges(10);
        checkOutput("t3_fall_on_fall", wkup_pend[2], 1);
        @(negedge mclk); wkup_clear = 4'b0100;
        @(negedge mclk); wkup_clear = '0; wkup_edge_sel[5:4] = 2'b11; wkup_in[2] = 1'b1;
        waitEdges(10);
        checkOutput("t3_both_rise", wkup_pend[2], 1);
        @(negedge mclk); wkup_clear = 4'b0100;
        @(negedge mclk); wkup_clear = '0; wkup_in[2] = 1'b0;
        waitEdges(10);
        checkOutput("t3_both_fall", wkup_pend[2], 1);
        @(negedge mclk); wkup_clear = 4'b0100;
        @(negedge mclk); wkup_clear = '0; wkup_edge_sel[5:4] = 2'b00; wkup_in[2] = 1'b1;
        waitEdges(10);
        checkOutput("t3_off_rise", wkup_pend[2], 0);

        // Scenario 4: ack walks the priority encoder
        @(negedge mclk); wkup_clear = '1;
        @(negedge mclk);
        wkup_clear = '0; wkup_edge_sel[7:6] = 2'b01; wkup_en[3] = 1'b1;
        wkup_in[3] = 1'b1; wkup_in[1] = 1'b1;
        waitEdges(10);
        checkOutput("t4_pend", wkup_pend, 4'b1010);
        checkOutput("t4_id", wkup_id, 1);
        @(negedge mclk); wkup_ack = 1'b1;
        waitEdges(1);
        checkOutput("t4_ack1_pend", wkup_pend, 4'b1000);
        checkOutput("t4_ack1_id", wkup_id, 3);
        @(negedge mclk); wkup_ack = 1'b0;
        @(negedge mclk); wkup_ack = 1'b1;
        waitEdges(1);
        checkOutput("t4_ack2_pend", wkup_pend, 0);
        checkOutput("t4_ack2_out", wkup_out, 0);
        @(negedge mclk); wkup_ack = 1'b0;

        // Scenario 5: set beats simultaneous clear
        @(negedge mclk); wkup_in[0] = 1'b0;
        repeat (10) @(posedge mclk);
        @(negedge mclk); wkup_in[0] = 1'b1;
        repeat (4) @(posedge mclk);
        @(negedge mclk); wkup_clear = 4'b0001;
        waitEdges(1);
        checkOutput("t5_set_wins", wkup_pend[0], 1);
        waitEdges(1);
        checkOutput("t5_clear_alone", wkup_pend[0], 0);
        @(negedge mclk); wkup_clear = '0;

        // Scenario 6: enable mask, then asynchronous reset
        @(negedge mclk); wkup_en[3] = 1'b0; wkup_in[3] = 1'b0;
        repeat (10) @(posedge mclk);
        @(negedge mclk); wkup_in[3] = 1'b1;
        waitEdges(10);
        checkOutput("t6_disabled", wkup_pend[3], 0);
        @(negedge mclk); wkup_edge_sel[1:0] = 2'b11; wkup_in[0] = 1'b0;
        waitEdges(10);
        checkOutput("t6_pre_reset", wkup_pend[0], 1);
        @(posedge mclk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_async_pend", wkup_pend, 0);
        checkOutput("t6_async_out", wkup_out, 0);
        checkOutput("t6_async_id", wkup_id, 0);
        @(negedge mclk);
        applyStimulus('0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge mclk);
        @(negedge mclk); reset_n = 1'b1;

        // Random traffic with occasional mid-cycle resets
        wkup_en = '1;
        wkup_edge_sel = 8'b11_10_01_11;
        for (int c = 0; c < 4000; c++) begin
            @(negedge mclk);
            #1;
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 5) == 0) wkup_in[b] = ~wkup_in[b];
            end
            if ($urandom_range(0, 63) == 0) wkup_en = NR'($urandom);
            if ($urandom_range(0, 63) == 0) wkup_edge_sel = (2*NR)'($urandom);
            wkup_clear = ($urandom_range(0, 15) == 0) ? NR'($urandom) : '0;
            wkup_ack   = ($urandom_range(0, 7) == 0);
            if (c % 1000 == 500) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(negedge mclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
